// File: rtl/pwm_bank.sv
// Multi-channel PWM peripheral on the J1 I/O bus. All channels share one period counter.
// Period and duty registers are double-buffered and committed at period wrap.
module pwm_bank #(
  parameter int CHANNELS = 3,
  parameter int CNT_W    = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         d_in,
  input  logic                cs,
  input  logic [3:0]          addr,
  input  logic                rd,
  input  logic                wr,
  output logic [15:0]         d_out,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                irq
);

  logic                run_r;
  logic                inv_r;
  logic                wrap_r;
  logic                pend_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    p_sh_r;
  logic [CNT_W-1:0]    p_act_r;
  logic [CNT_W-1:0]    d_sh_r  [CHANNELS];
  logic [CNT_W-1:0]    d_act_r [CHANNELS];
  logic [15:0]         d_out_r;
  logic [CHANNELS-1:0] pwm_r;

  logic                we_s;
  logic                re_s;
  logic                ctrl_we_s;
  logic                wrap_s;
  logic                duty_sel_s;
  logic                sh_we_s;
  logic [CNT_W-1:0]    sel_duty_s;
  logic [CHANNELS-1:0] raw_s;
  logic [15:0]         rdata_s;

  // Bus decode, wrap detection and per-channel compare
  always_comb begin
    we_s       = cs && wr;
    re_s       = cs && rd;
    ctrl_we_s  = we_s && (addr == 4'h0);
    wrap_s     = run_r && (cnt_r == p_act_r);
    duty_sel_s = 1'b0;
    sel_duty_s = '0;
    raw_s      = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      duty_sel_s = duty_sel_s || (addr == 4'(8 + n));
      sel_duty_s = (addr == 4'(8 + n)) ? d_sh_r[n] : sel_duty_s;
      raw_s[n]   = (cnt_r < d_act_r[n]);
    end
    sh_we_s = we_s && ((addr == 4'h1) || duty_sel_s);
  end

  // Read mux; sampled from current register state, so a same-edge write is not seen
  always_comb begin
    rdata_s = 16'd0;
    case (addr)
      4'h0:    rdata_s[1:0] = {inv_r, run_r};
      4'h1:    rdata_s[CNT_W-1:0] = p_sh_r;
      4'h2:    rdata_s[1:0] = {pend_r, wrap_r};
      default: begin
        if (duty_sel_s) begin
          rdata_s[CNT_W-1:0] = sel_duty_s;
        end else begin
          rdata_s = 16'd0;
        end
      end
    endcase
  end

  // Registers, counter, commit logic and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_r   <= 1'b0;
      inv_r   <= 1'b0;
      wrap_r  <= 1'b0;
      pend_r  <= 1'b0;
      cnt_r   <= '0;
      p_sh_r  <= '0;
      p_act_r <= '0;
      d_out_r <= 16'd0;
      pwm_r   <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        d_sh_r[n]  <= '0;
        d_act_r[n] <= '0;
      end
    end else begin
      if (ctrl_we_s) begin
        run_r <= d_in[0];
        inv_r <= d_in[1];
      end
      if (we_s && (addr == 4'h1)) begin
        p_sh_r <= d_in[CNT_W-1:0];
      end
      for (int n = 0; n < CHANNELS; n++) begin
        if (we_s && (addr == 4'(8 + n))) begin
          d_sh_r[n] <= d_in[CNT_W-1:0];
        end
      end

      // Actives follow shadows while stopped; otherwise they load only at wrap
      if (!run_r || wrap_s) begin
        p_act_r <= p_sh_r;
        for (int n = 0; n < CHANNELS; n++) begin
          d_act_r[n] <= d_sh_r[n];
        end
      end

      if (!run_r || wrap_s || (ctrl_we_s && !d_in[0])) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + 1'b1;
      end

      // A shadow write on the wrap edge outranks the commit, so it stays pending
      if (!run_r) begin
        pend_r <= 1'b0;
      end else if (sh_we_s) begin
        pend_r <= 1'b1;
      end else if (wrap_s) begin
        pend_r <= 1'b0;
      end

      if (wrap_s) begin
        wrap_r <= 1'b1;
      end else if (we_s && (addr == 4'h2) && d_in[0]) begin
        wrap_r <= 1'b0;
      end

      for (int n = 0; n < CHANNELS; n++) begin
        pwm_r[n] <= run_r ? (raw_s[n] ^ inv_r) : inv_r;
      end

      if (re_s) begin
        d_out_r <= rdata_s;
      end
    end
  end

  assign d_out   = d_out_r;
  assign pwm_out = pwm_r;
  assign irq     = wrap_r;

endmodule
